// File: rtl/button_conditioner.sv
// N-channel push-button front end: 2-flop sync, debounce, press/release strobes
// and optional hold-to-repeat press strobes, one independent btn_chan per channel.

module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic rep_en,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} st_t;

  logic          s1, s2;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  st_t           st;
  logic          win_done, rise, fall;

  // The window completes on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  assign win_done = (s2 != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise     = win_done && !level;
  assign fall     = win_done && level;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      dcnt  <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rcnt  <= '0;
      st    <= IDLE;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;

      if (s2 == level)   dcnt <= '0;
      else if (win_done) begin
        level <= ~level;
        dcnt  <= '0;
      end else           dcnt <= dcnt + DW'(1);

      // A debounced fall wins over any repeat tick landing on the same cycle.
      if (fall) begin
        rel  <= 1'b1;
        rcnt <= '0;
        st   <= IDLE;
      end else begin
        case (st)
          IDLE: if (rise) begin
            press <= 1'b1;
            rcnt  <= '0;
            st    <= rep_en ? DELAY : HOLD;
          end
          DELAY: begin
            if (!rep_en) begin
              rcnt <= '0;
              st   <= HOLD;
            end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
              press <= 1'b1;
              rcnt  <= '0;
              st    <= REPEAT;
            end else rcnt <= rcnt + RW'(1);
          end
          REPEAT: begin
            if (!rep_en) begin
              rcnt <= '0;
              st   <= HOLD;
            end else if (rcnt == RW'(REPEAT_RATE - 1)) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else rcnt <= rcnt + RW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_in[i]),
      .rep_en(repeat_en[i]),
      .level (btn_level[i]),
      .press (btn_press[i]),
      .rel   (btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus, each cycle
// compared against an event-level reference model.

module tb_button_conditioner;
  localparam int N  = 3;
  localparam int DB = 100;
  localparam int RD = 300;
  localparam int RR = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in, repeat_en;
  logic [N-1:0] btn_level, btn_press, btn_release;

  button_conditioner #(.N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: input delay line, disagreement run length, and repeat
  // strobes from elapsed time since the accepted press.
  logic [N-1:0] d1 = '0, d2 = '0, m_lvl = '0, m_press = '0, m_rel = '0, rep_ok = '0;
  int run [N];
  int t_rise [N];

  task automatic step();
    logic sv;
    int   el;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < N; c++) begin
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (rst) begin
        d1[c] = 1'b0; d2[c] = 1'b0; run[c] = 0; m_lvl[c] = 1'b0; rep_ok[c] = 1'b0;
      end else begin
        sv = d2[c]; d2[c] = d1[c]; d1[c] = btn_in[c];
        run[c] = (sv != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == DB) begin
          run[c]   = 0;
          m_lvl[c] = sv;
          if (sv) begin m_press[c] = 1'b1; t_rise[c] = cyc; rep_ok[c] = repeat_en[c]; end
          else begin m_rel[c] = 1'b1; rep_ok[c] = 1'b0; end
        end else if (m_lvl[c]) begin
          if (!repeat_en[c]) rep_ok[c] = 1'b0;
          el = cyc - t_rise[c];
          if (rep_ok[c] && el >= RD && (el - RD) % RR == 0) m_press[c] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_in = '1; repeat_en = '0;
    for (int i = 1; i <= 2; i++) begin
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        nerr++; $display("FAIL reset_hold i=%0d got=%b required=0", i, {btn_level, btn_press, btn_release});
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 110; i++) begin
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL reset_model cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
      ncmp++;
      if ({btn_level, btn_press} !== {(i >= 102) ? 3'b111 : 3'b000, (i == 102) ? 3'b111 : 3'b000}) begin
        nerr++; $display("FAIL reset_accept i=%0d got lvl=%b press=%b", i, btn_level, btn_press);
      end
    end
    btn_in = '0;
    for (int i = 1; i <= 110; i++) begin
      step();
      ncmp++;
      if (btn_release !== ((i == 102) ? 3'b111 : 3'b000)) begin
        nerr++; $display("FAIL reset_release i=%0d got=%b", i, btn_release);
      end
    end
  endtask

  task automatic test_bounce();
    int dur [6] = '{99, 5, 99, 120, 1000, 120};
    bit lv  [6] = '{1, 0, 1, 0, 1, 0};
    int np = 0;
    repeat_en = '0;
    for (int p = 0; p < 6; p++) begin
      btn_in[0] = lv[p];
      for (int i = 1; i <= dur[p]; i++) begin
        step();
        ncmp++;
        if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
          nerr++; $display("FAIL bounce_model cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
        end
        if (p < 4) begin
          ncmp++;
          if ({btn_level[0], btn_press[0], btn_release[0]} !== 3'b000) begin
            nerr++; $display("FAIL bounce_glitch p=%0d i=%0d got=%b required=000", p, i, {btn_level[0], btn_press[0], btn_release[0]});
          end
        end else if (p == 4) begin
          np += btn_press[0];
          ncmp++;
          if (btn_press[0] !== (i == 102)) begin
            nerr++; $display("FAIL bounce_press i=%0d got=%b", i, btn_press[0]);
          end
        end else begin
          ncmp++;
          if (btn_release[0] !== (i == 102)) begin
            nerr++; $display("FAIL bounce_release i=%0d got=%b", i, btn_release[0]);
          end
        end
      end
    end
    ncmp++;
    if (np != 1) begin nerr++; $display("FAIL bounce_press_count got=%0d required=1", np); end
  endtask

  // drop == 0: repeat stays enabled; otherwise repeat_en[1] falls after cycle 'drop'.
  task automatic test_repeat(input int drop);
    int  np = 0;
    logic ep;
    repeat_en = 3'b010; btn_in = 3'b010;
    for (int i = 1; i <= 1120; i++) begin
      if (i == drop + 1 && drop != 0) repeat_en[1] = 1'b0;
      if (i == 1001) btn_in[1] = 1'b0;
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL repeat_model drop=%0d cyc=%0d got=%b required=%b", drop, cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
      ep = (i == 102) || (i >= 402 && i < 1102 && (i - 402) % RR == 0 && (drop == 0 || i <= drop));
      np += btn_press[1];
      ncmp++;
      if ({btn_press[1], btn_release[1]} !== {ep, (i == 1102)}) begin
        nerr++; $display("FAIL repeat_strobe drop=%0d i=%0d got=%b required=%b", drop, i, {btn_press[1], btn_release[1]}, {ep, (i == 1102)});
      end
    end
    ncmp++;
    if (np != ((drop == 0) ? 15 : 3)) begin
      nerr++; $display("FAIL repeat_count drop=%0d got=%0d required=%0d", drop, np, (drop == 0) ? 15 : 3);
    end
    repeat_en = '0;
  endtask

  task automatic test_simultaneous();
    repeat_en = '0; btn_in = 3'b101;
    for (int i = 1; i <= 420; i++) begin
      if (i == 51)  btn_in[2] = 1'b0;
      if (i == 81)  btn_in[2] = 1'b1;
      if (i == 301) btn_in = '0;
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL simul_model cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
      ncmp++;
      if (btn_press !== {(i == 182), 1'b0, (i == 102)}) begin
        nerr++; $display("FAIL simul_press i=%0d got=%b", i, btn_press);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic ep, el;
    repeat_en = 3'b010; btn_in = 3'b010;
    for (int i = 1; i <= 900; i++) begin
      if (i == 421) rst = 1'b1;
      if (i == 423) rst = 1'b0;
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL rstmid_model cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
      ep = (i == 102) || (i == 402) || (i == 524) || (i == 824) || (i == 874);
      el = (i >= 102 && i <= 420) || (i >= 524);
      ncmp++;
      if ({btn_level[1], btn_press[1], btn_release[1]} !== {el, ep, 1'b0}) begin
        nerr++; $display("FAIL rstmid_ch1 i=%0d got=%b required=%b", i, {btn_level[1], btn_press[1], btn_release[1]}, {el, ep, 1'b0});
      end
    end
    btn_in = '0;
    for (int i = 1; i <= 120; i++) begin
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL rstmid_rel cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
    end
    repeat_en = '0;
  endtask

  task automatic test_random();
    int hold [N] = '{0, 0, 0};
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 99) : $urandom_range(100, 700);
        end
        hold[c]--;
        if ($urandom_range(0, 299) == 0) repeat_en[c] = ~repeat_en[c];
      end
      rst = ($urandom_range(0, 1499) == 0);
      step();
      ncmp++;
      if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
        nerr++; $display("FAIL random_model cyc=%0d got=%b required=%b", cyc, {btn_level, btn_press, btn_release}, {m_lvl, m_press, m_rel});
      end
      ncmp++;
      if ((btn_press & btn_release) !== '0) begin
        nerr++; $display("FAIL random_overlap cyc=%0d press=%b release=%b", cyc, btn_press, btn_release);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin run[c] = 0; t_rise[c] = 0; end
    rst = 1'b1; btn_in = '0; repeat_en = '0;
    test_reset();
    test_bounce();
    test_repeat(0);
    test_repeat(500);
    test_simultaneous();
    test_reset_mid_repeat();
    repeat_en = 3'b101;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
